// File: rtl/mem_port_arbiter_pkg.sv
// mem_pkg: shared encodings, state/requester enums and size helper for the RAM port arbiter
package mem_pkg;
  localparam int ADDR_W = 32;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  typedef enum logic {REQ_FETCH, REQ_DATA} req_e;
  function automatic logic [2:0] bytes_of(input logic [1:0] size);
    return size == SZ_B ? 3'd1 : size == SZ_H ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request handshakes plus the byte-wide RAM port
interface mem_port_arbiter_if;
  import mem_pkg::*;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_done;
  logic [31:0]       d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_writing;
  logic [7:0]        ram_data;
  logic [7:0]        ram_loaded_data;
  logic              busy;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_loaded_data,
    output if_done, if_data, d_done, d_rdata, ram_addr, ram_writing, ram_data, busy
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_loaded_data,
    input  if_done, if_data, d_done, d_rdata, ram_addr, ram_writing, ram_data, busy
  );
endinterface

// File: rtl/mem_port_arbiter_byte_sequencer.sv
// mem_byte_sequencer: byte counter, RAM address stepper and byte shift-in/shift-out register
module mem_byte_sequencer
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              we_i,
  input  logic              adv_i,
  input  logic              last_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [31:0]       wdata_i,
  input  logic [7:0]        rbyte_i,
  output logic [2:0]        cnt_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        wbyte_o,
  output logic [31:0]       rdata_o
);
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wbyte_q;
  logic [31:0]       sh_q;
  logic [31:0]       rdata_d;
  logic [1:0]        idx;
  assign idx = 2'(cnt_q - 3'd1);
  // the byte returned by RAM belongs to the address issued one cycle earlier (index cnt-1)
  always_comb begin
    rdata_d = sh_q;
    if (cnt_q != 3'd0) rdata_d[{idx, 3'b000} +: 8] = rbyte_i;
  end
  // load latches the base and store word; each advance steps address and moves one byte
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      wbyte_q <= 8'd0;
      sh_q    <= 32'd0;
    end else if (load_i) begin
      cnt_q   <= 3'd0;
      addr_q  <= base_i;
      wbyte_q <= we_i ? wdata_i[7:0] : 8'd0;
      sh_q    <= we_i ? {8'd0, wdata_i[31:8]} : 32'd0;
    end else if (adv_i) begin
      cnt_q   <= cnt_q + 3'd1;
      addr_q  <= last_i ? '0 : addr_q + ADDR_W'(1);
      wbyte_q <= (last_i || !we_i) ? 8'd0 : sh_q[7:0];
      sh_q    <= we_i ? sh_q >> 8 : rdata_d;
    end
  end
  assign cnt_o   = cnt_q;
  assign addr_o  = addr_q;
  assign wbyte_o = wbyte_q;
  assign rdata_o = rdata_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one byte-wide RAM port between fetch and load/store
module mem_port_arbiter
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  state_e      state_q;
  req_e        req_q;
  req_e        last_q;
  logic        we_q;
  logic [2:0]  n_q;
  logic        if_done_q;
  logic        d_done_q;
  logic        ram_writing_q;
  logic [31:0] if_data_q;
  logic [31:0] d_rdata_q;
  logic        gnt_data;
  logic        load;
  logic        adv;
  logic        fin;
  logic        we_d;
  logic [2:0]  cnt;
  logic [31:0] rdata;
  assign gnt_data = bus.d_req && (!bus.if_req || last_q == REQ_FETCH);
  assign load     = state_q == IDLE && (bus.if_req || bus.d_req);
  assign adv      = state_q == READ || state_q == WRITE;
  assign fin      = cnt + 3'd1 >= n_q;
  assign we_d     = load ? gnt_data && bus.d_we : we_q;
  mem_byte_sequencer u_seq (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .we_i    (we_d),
    .adv_i   (adv),
    .last_i  (fin),
    .base_i  (gnt_data ? bus.d_addr : bus.if_addr),
    .wdata_i (bus.d_wdata),
    .rbyte_i (bus.ram_loaded_data),
    .cnt_o   (cnt),
    .addr_o  (bus.ram_addr),
    .wbyte_o (bus.ram_data),
    .rdata_o (rdata)
  );
  // arbitration and transfer sequencing; done pulses and result words are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= REQ_FETCH;
      last_q        <= REQ_FETCH;
      we_q          <= 1'b0;
      n_q           <= 3'd4;
      if_done_q     <= 1'b0;
      d_done_q      <= 1'b0;
      ram_writing_q <= 1'b0;
      if_data_q     <= 32'd0;
      d_rdata_q     <= 32'd0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        IDLE: if (load) begin
          state_q       <= we_d ? WRITE : READ;
          req_q         <= gnt_data ? REQ_DATA : REQ_FETCH;
          last_q        <= gnt_data ? REQ_DATA : REQ_FETCH;
          we_q          <= we_d;
          n_q           <= gnt_data ? bytes_of(bus.d_size) : 3'd4;
          ram_writing_q <= we_d;
        end
        READ: if (cnt == n_q) begin
          state_q <= DONE;
          if (req_q == REQ_FETCH) begin
            if_done_q <= 1'b1;
            if_data_q <= rdata;
          end else begin
            d_done_q  <= 1'b1;
            d_rdata_q <= rdata;
          end
        end
        WRITE: if (fin) begin
          state_q       <= DONE;
          ram_writing_q <= 1'b0;
          d_done_q      <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.if_done     = if_done_q;
  assign bus.if_data     = if_data_q;
  assign bus.d_done      = d_done_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.ram_writing = ram_writing_q;
  assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, byte sequencing, wrap and reset abort
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus();
  mem_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0]  mem [0:1023];
  logic [7:0]  rd = 8'd0;
  int          wn = 0;
  int          cyc = 0;
  logic [31:0] wl_addr [64];
  logic [7:0]  wl_data [64];
  int          wl_cyc  [64];
  int          passed = 0;
  int          total = 0;
  assign bus.ram_loaded_data = rd;
  // byte RAM with one-cycle read latency, plus a log of every write
  always @(posedge clk) begin
    cyc = cyc + 1;
    rd <= mem[bus.ram_addr[9:0]];
    if (bus.ram_writing) begin
      mem[bus.ram_addr[9:0]] = bus.ram_data;
      wl_addr[wn & 63] = bus.ram_addr;
      wl_data[wn & 63] = bus.ram_data;
      wl_cyc[wn & 63]  = cyc;
      wn = wn + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic run(input bit is_d, output int k, output logic [31:0] a1, output logic [31:0] a2);
    k = 0;
    a1 = 'x;
    a2 = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) a1 = bus.ram_addr;
      if (i == 2) a2 = bus.ram_addr;
      if (is_d ? bus.d_done : bus.if_done) begin
        k = i;
        break;
      end
    end
  endtask
  initial begin
    int k, w0, nd, both, dcnt;
    logic [31:0] a1, a2, dval;
    logic [3:0] ord;
    int t [4];
    for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_size = 2'd0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr", 32'(bus.ram_writing), 32'd0);
    chk("rst_addr", bus.ram_addr, 32'd0);
    chk("rst_dones", {30'd0, bus.if_done, bus.d_done}, 32'd0);
    chk("rst_data", bus.if_data | bus.d_rdata | 32'(bus.ram_data), 32'd0);
    rst = 1'b0;
    mem[10'h100] = 8'h13; mem[10'h101] = 8'h00; mem[10'h102] = 8'h00; mem[10'h103] = 8'h93;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    run(1'b0, k, a1, a2);
    bus.if_req = 1'b0;
    chk("fetch_lat", k, 6);
    chk("fetch_data", bus.if_data, 32'h93000013);
    chk("fetch_a0", a1, 32'h100);
    chk("fetch_a1", a2, 32'h101);
    chk("fetch_no_d", 32'(bus.d_done), 32'd0);
    @(negedge clk);
    chk("fetch_idle", {30'd0, bus.busy, bus.if_done}, 32'd0);
    w0 = wn;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'd2; bus.d_addr = 32'h20; bus.d_wdata = 32'hDEADBEEF;
    run(1'b1, k, a1, a2);
    bus.d_req = 1'b0;
    chk("sw_lat", k, 5);
    chk("sw_nwr", wn - w0, 4);
    chk("sw_bytes", {wl_data[(w0+3)&63], wl_data[(w0+2)&63], wl_data[(w0+1)&63], wl_data[w0&63]}, 32'hDEADBEEF);
    chk("sw_addr0", wl_addr[w0&63], 32'h20);
    chk("sw_addr3", wl_addr[(w0+3)&63], 32'h23);
    chk("sw_consec", wl_cyc[(w0+3)&63] - wl_cyc[w0&63], 3);
    chk("sw_mem", {mem[10'h23], mem[10'h22], mem[10'h21], mem[10'h20]}, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_wr_off", 32'(bus.ram_writing), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_addr = 32'h20;
    nd = 0; both = 0; ord = 4'd0; dval = 'x; dcnt = 0;
    for (int i = 0; i < 4; i++) t[i] = 0;
    for (int i = 1; i <= 60 && nd < 4; i++) begin
      @(negedge clk);
      if (bus.d_done && bus.if_done) both++;
      if (bus.d_done || bus.if_done) begin
        ord = {ord[2:0], bus.d_done};
        t[nd] = i;
        nd++;
        if (bus.d_done && dcnt == 0) begin
          dval = bus.d_rdata;
          dcnt++;
        end
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    chk("rr_count", nd, 4);
    chk("rr_order", 32'(ord), 32'b1010);
    chk("rr_both", both, 0);
    chk("rr_t0", t[0], 3);
    chk("rr_t1", t[1], 10);
    chk("rr_t2", t[2], 14);
    chk("rr_t3", t[3], 21);
    chk("lb_data", dval, 32'h000000EF);
    chk("rr_fetch", bus.if_data, 32'h93000013);
    @(negedge clk);
    mem[10'h3FF] = 8'h34; mem[10'h000] = 8'h12;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd1; bus.d_addr = 32'hFFFFFFFF;
    run(1'b1, k, a1, a2);
    bus.d_req = 1'b0;
    chk("lh_lat", k, 4);
    chk("lh_a0", a1, 32'hFFFFFFFF);
    chk("lh_a1", a2, 32'h00000000);
    chk("lh_data", bus.d_rdata, 32'h00001234);
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'd2; bus.d_addr = 32'h40; bus.d_wdata = 32'h11223344;
    repeat (2) @(negedge clk);
    chk("rs_wr_mid", 32'(bus.ram_writing), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rs_wr", 32'(bus.ram_writing), 32'd0);
    chk("rs_busy", 32'(bus.busy), 32'd0);
    chk("rs_addr", bus.ram_addr, 32'd0);
    rst = 1'b0;
    bus.d_req = 1'b0;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.d_done) nd++;
    end
    chk("rs_no_done", nd, 0);
    chk("rs_mem", {8'd0, mem[10'h42], mem[10'h41], mem[10'h40]}, 32'h00003344);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
